// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;
    localparam int LINE_W   = 128;
    localparam int WORD_W   = 32;
    localparam int BEATS    = 4;
    localparam int OFFSET_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESPOND
    } state_t;
endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side request/response and backing-memory refill signals of inst_cache.
// slave: the cache's view. master: the fetch queue plus memory subsystem.
interface inst_cache_if;
    import icache_pkg::*;

    logic [31:0]         pc_in;
    logic                cache_rd_en;
    logic                cache_abort;
    logic                cache_stall;
    logic [LINE_W-1:0]   dout;
    logic                dout_valid;
    logic [31:0]         mem_addr;
    logic                mem_rd_req;
    logic [WORD_W-1:0]   mem_rd_data;
    logic                mem_rd_valid;

    modport slave (
        input  pc_in, cache_rd_en, cache_abort, mem_rd_data, mem_rd_valid,
        output cache_stall, dout, dout_valid, mem_addr, mem_rd_req
    );

    modport master (
        output pc_in, cache_rd_en, cache_abort, mem_rd_data, mem_rd_valid,
        input  cache_stall, dout, dout_valid, mem_addr, mem_rd_req
    );
endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage for inst_cache: one registered read port, one write
// port. Reset clears only the valid bits; tag and data are plain storage.
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    // Valid bits: cleared on reset, set when a refill installs a line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_idx] <= 1'b1;
    end

    // Tag/data write; a refill overwrites whatever the index held.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    // Registered read, captured when a request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_tag   <= '0;
            rd_data  <= '0;
        end else if (rd_en) begin
            rd_valid <= valid_q[rd_idx];
            rd_tag   <= tag_mem[rd_idx];
            rd_data  <= data_mem[rd_idx];
        end
    end
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. Returns one 128-bit line per
// accepted fetch; misses refill four 32-bit beats from backing memory.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module inst_cache
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    inst_cache_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    state_t                        state;
    logic [1:0]                    beat_cnt;
    logic                          abort_q;
    logic [31:0]                   req_addr;
    logic [BEATS-1:0][WORD_W-1:0]  line_buf;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_data;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic              abort_eff;
    logic              accept;
    logic              last_beat;
    logic [LINE_W-1:0] fill_line;

    assign req_idx   = req_addr[OFFSET_W +: IDX_W];
    assign req_tag   = req_addr[31 -: TAG_W];
    assign hit       = (state == LOOKUP) && rd_valid && (rd_tag == req_tag);
    // Abort stays in force from its assertion until the pending response slot.
    assign abort_eff = bus.cache_abort | abort_q;
    // A new request may be taken from IDLE, or pipelined behind a hit.
    assign accept    = bus.cache_rd_en && !bus.cache_abort &&
                       ((state == IDLE) || hit);
    assign last_beat = (state == REFILL) && bus.mem_rd_valid && (beat_cnt == 2'd3);
    assign fill_line = {bus.mem_rd_data, line_buf[2], line_buf[1], line_buf[0]};

    assign bus.cache_stall = (state == REFILL) || (state == RESPOND) ||
                             ((state == LOOKUP) && !hit);
    assign bus.dout_valid  = (hit || (state == RESPOND)) && !abort_eff;
    assign bus.dout        = (state == RESPOND) ? line_buf : rd_data;
    assign bus.mem_rd_req  = (state == REFILL);
    assign bus.mem_addr    = req_addr;

    icache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (accept),
        .rd_idx   (bus.pc_in[OFFSET_W +: IDX_W]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (last_beat),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (fill_line)
    );

    // Request/refill state machine; reset abandons any refill in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beat_cnt <= 2'd0;
            abort_q  <= 1'b0;
            req_addr <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr <= {bus.pc_in[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (accept)
                            req_addr <= {bus.pc_in[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        else
                            state <= IDLE;
                    end else begin
                        beat_cnt <= 2'd0;
                        abort_q  <= bus.cache_abort;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.cache_abort)
                        abort_q <= 1'b1;
                    if (bus.mem_rd_valid) begin
                        line_buf[beat_cnt] <= bus.mem_rd_data;
                        beat_cnt           <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            // An aborted refill still installs the line but skips its response.
                            state   <= abort_eff ? IDLE : RESPOND;
                            abort_q <= 1'b0;
                        end
                    end
                end
                RESPOND: begin
                    abort_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    // Count every lookup by outcome, aborted ones included; saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF)
                    hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF)
                    miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif
endmodule
